segre_mem_arbiter: RTL



---
 rtl/segre_mem_arbiter_if.sv | 60 ++++++
 rtl/segre_mem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter_if.sv
// Cache-miss, fill and main-memory signals around segre_mem_arbiter.
// master: the arbiter side; slave: the caches and memory that drive requests and responses.
// Optional perf counter outputs exist only when SEGRE_MEM_ARB_PERF_EN is defined.
interface segre_mem_arbiter_if #(
    parameter int unsigned ADDR_SIZE     = 32,
    parameter int unsigned LANE_SIZE     = 128,
    parameter int unsigned IC_INDEX_SIZE = 2,
    parameter int unsigned DC_INDEX_SIZE = 2
);
    logic                     ic_miss_i;
    logic [ADDR_SIZE-1:0]     ic_addr_i;
    logic                     ic_fill_o;
    logic [IC_INDEX_SIZE-1:0] ic_fill_index_o;
    logic                     dc_miss_i;
    logic [ADDR_SIZE-1:0]     dc_addr_i;
    logic                     dc_wb_i;
    logic [ADDR_SIZE-1:0]     dc_wb_addr_i;
    logic [LANE_SIZE-1:0]     dc_wb_data_i;
    logic                     dc_fill_o;
    logic [DC_INDEX_SIZE-1:0] dc_fill_index_o;
    logic [LANE_SIZE-1:0]     fill_data_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [ADDR_SIZE-1:0]     mem_addr_o;
    logic [LANE_SIZE-1:0]     mem_wr_data_o;
    logic                     mem_ready_i;
    logic [LANE_SIZE-1:0]     mem_rd_data_i;
    logic                     busy_o;
`ifdef SEGRE_MEM_ARB_PERF_EN
    logic [31:0]              perf_ic_fills_o;
    logic [31:0]              perf_dc_fills_o;
    logic [31:0]              perf_wait_cycles_o;
`endif

    modport master (
`ifdef SEGRE_MEM_ARB_PERF_EN
        output perf_ic_fills_o, output perf_dc_fills_o, output perf_wait_cycles_o,
`endif
        input  ic_miss_i, input ic_addr_i,
        output ic_fill_o, output ic_fill_index_o,
        input  dc_miss_i, input dc_addr_i, input dc_wb_i, input dc_wb_addr_i, input dc_wb_data_i,
        output dc_fill_o, output dc_fill_index_o, output fill_data_o,
        output mem_req_o, output mem_we_o, output mem_addr_o, output mem_wr_data_o,
        input  mem_ready_i, input mem_rd_data_i,
        output busy_o
    );

    modport slave (
`ifdef SEGRE_MEM_ARB_PERF_EN
        input  perf_ic_fills_o, input perf_dc_fills_o, input perf_wait_cycles_o,
`endif
        output ic_miss_i, output ic_addr_i,
        input  ic_fill_o, input ic_fill_index_o,
        output dc_miss_i, output dc_addr_i, output dc_wb_i, output dc_wb_addr_i, output dc_wb_data_i,
        input  dc_fill_o, input dc_fill_index_o, input fill_data_o,
        input  mem_req_o, input mem_we_o, input mem_addr_o, input mem_wr_data_o,
        output mem_ready_i, output mem_rd_data_i,
        input  busy_o
    );
endinterface

// File: rtl/segre_mem_arbiter.sv
// Round-robin sharing of one memory port between icache refill and dcache writeback+refill.
// Latency: grant N, memory request N+1 (held until mem_ready_i), fill pulse one cycle after completion.
// Backpressure: misses wait in IDLE while busy; mem_ready_i stalls the request states. Perf macro: SEGRE_MEM_ARB_PERF_EN.
module segre_mem_arbiter #(
    parameter int unsigned ADDR_SIZE     = 32,
    parameter int unsigned LANE_SIZE     = 128,
    parameter int unsigned OFFSET_SIZE   = 4,
    parameter int unsigned IC_INDEX_SIZE = 2,
    parameter int unsigned DC_INDEX_SIZE = 2
) (
    input logic                 clk_i,
    input logic                 rsn_i,
    segre_mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, IC_FILL, DC_WB, DC_FILL, RESP} state_t;

    localparam logic [ADDR_SIZE-1:0] LINE_MASK = {{(ADDR_SIZE-OFFSET_SIZE){1'b1}}, {OFFSET_SIZE{1'b0}}};
    localparam logic [IC_INDEX_SIZE-1:0] IC_ONE = {{(IC_INDEX_SIZE-1){1'b0}}, 1'b1};
    localparam logic [DC_INDEX_SIZE-1:0] DC_ONE = {{(DC_INDEX_SIZE-1){1'b0}}, 1'b1};

    state_t                   state;
    logic                     last_dc;    // 1: dcache was granted last, so icache wins the next tie
    logic                     resp_dc;    // owner of the transaction in flight
    logic [ADDR_SIZE-1:0]     miss_addr;
    logic [ADDR_SIZE-1:0]     wb_addr;
    logic [LANE_SIZE-1:0]     wb_data;
    logic [LANE_SIZE-1:0]     fill_data;
    logic [IC_INDEX_SIZE-1:0] ic_idx;
    logic [DC_INDEX_SIZE-1:0] dc_idx;
    logic                     ic_fill;
    logic                     dc_fill;
    logic                     grant_ic;

    // Icache wins when alone or when the dcache had the previous grant.
    assign grant_ic = bus.ic_miss_i && (!bus.dc_miss_i || last_dc);

    // Arbitration FSM: grant in IDLE, optional writeback, read, then one-cycle fill response.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state     <= IDLE;
            last_dc   <= 1'b1;
            resp_dc   <= 1'b0;
            miss_addr <= '0;
            wb_addr   <= '0;
            wb_data   <= '0;
            fill_data <= '0;
            ic_idx    <= '0;
            dc_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ic) begin
                        state     <= IC_FILL;
                        last_dc   <= 1'b0;
                        resp_dc   <= 1'b0;
                        miss_addr <= bus.ic_addr_i & LINE_MASK;
                    end else if (bus.dc_miss_i) begin
                        last_dc   <= 1'b1;
                        resp_dc   <= 1'b1;
                        miss_addr <= bus.dc_addr_i & LINE_MASK;
                        if (bus.dc_wb_i) begin
                            state   <= DC_WB;
                            wb_addr <= bus.dc_wb_addr_i & LINE_MASK;
                            wb_data <= bus.dc_wb_data_i;
                        end else begin
                            state <= DC_FILL;
                        end
                    end
                end
                IC_FILL, DC_FILL: begin
                    if (bus.mem_ready_i) begin
                        fill_data <= bus.mem_rd_data_i;
                        state     <= RESP;
                    end
                end
                DC_WB: begin
                    if (bus.mem_ready_i) begin
                        state <= DC_FILL;
                    end
                end
                RESP: begin
                    if (resp_dc) begin
                        dc_idx <= dc_idx + DC_ONE;
                    end else begin
                        ic_idx <= ic_idx + IC_ONE;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port decode: idle states present an all-zero request.
    always_comb begin
        bus.mem_req_o     = 1'b0;
        bus.mem_we_o      = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_wr_data_o = '0;
        case (state)
            IC_FILL, DC_FILL: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = miss_addr;
            end
            DC_WB: begin
                bus.mem_req_o     = 1'b1;
                bus.mem_we_o      = 1'b1;
                bus.mem_addr_o    = wb_addr;
                bus.mem_wr_data_o = wb_data;
            end
            default: ;
        endcase
    end

    assign ic_fill             = (state == RESP) && !resp_dc;
    assign dc_fill             = (state == RESP) && resp_dc;
    assign bus.ic_fill_o       = ic_fill;
    assign bus.dc_fill_o       = dc_fill;
    assign bus.ic_fill_index_o = ic_idx;
    assign bus.dc_fill_index_o = dc_idx;
    assign bus.fill_data_o     = (state == RESP) ? fill_data : '0;
    assign bus.busy_o          = (state != IDLE);

`ifdef SEGRE_MEM_ARB_PERF_EN
    logic [31:0] perf_ic_fills;
    logic [31:0] perf_dc_fills;
    logic [31:0] perf_wait_cycles;
    logic        serving_ic;
    logic        serving_dc;
    logic        waiting;

    // A miss is being served only while its own transaction occupies the FSM.
    assign serving_ic = (state == IC_FILL) || ic_fill;
    assign serving_dc = (state == DC_WB) || (state == DC_FILL) || dc_fill;
    assign waiting    = (bus.ic_miss_i && !serving_ic) || (bus.dc_miss_i && !serving_dc);

    // Event counters; each wraps naturally at 2**32.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            perf_ic_fills    <= '0;
            perf_dc_fills    <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (ic_fill) perf_ic_fills <= perf_ic_fills + 32'd1;
            if (dc_fill) perf_dc_fills <= perf_dc_fills + 32'd1;
            if (waiting) perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end

    assign bus.perf_ic_fills_o    = perf_ic_fills;
    assign bus.perf_dc_fills_o    = perf_dc_fills;
    assign bus.perf_wait_cycles_o = perf_wait_cycles;
`endif
endmodule
